// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, addresses the instruction
// memory (combinational read) and loads the IF/ID pipeline register. Handles
// stall, redirect, a sticky halt, and keeps a saturating count of delivered
// instructions.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] InstructionAddress,
  input  logic [15:0] Instruction,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectTarget,
  input  logic        Halt,
  output logic [15:0] IfIdInstruction,
  output logic [15:0] IfIdPC,
  output logic        IfIdValid,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  // The all-zero word is the NOP encoding used for flushed IF/ID slots.
  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    STALLED,
    HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] pc_next_seq;
  logic [15:0] fetch_count_inc;

  // Sequential successor of the PC (16-bit modulo wrap is intended) and the
  // saturating increment of the delivered-instruction counter.
  assign pc_next_seq     = pc_q + PC_STEP;
  assign fetch_count_inc = (fetch_count_q == 16'hFFFF) ? fetch_count_q
                                                       : fetch_count_q + 16'd1;

  // State and datapath registers; synchronous reset has top priority.
  always_ff @(posedge Clk) begin
    // NOTE: every register here uses non-blocking assignments so all of them
    // sample the values computed before this edge, independent of order.
    if (Reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      ifid_instr_q  <= NOP;
      ifid_pc_q     <= 16'h0000;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and next-register logic: Redirect > Halt > Stall > fetch.
  always_comb begin
    // NOTE: every signal gets a hold value first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    if (state_q != HALTED) begin
      if (Redirect) begin
        // Squash the in-flight fetch; the target is fetched on the next edge
        // even if Stall is also high.
        state_d      = FETCH;
        pc_d         = RedirectTarget;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
      end else if (Halt) begin
        state_d      = HALTED;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
      end else if (Stall) begin
        // Everything holds; the held PC is fetched once Stall drops.
        state_d = STALLED;
      end else if (state_q == BOOT) begin
        // One settling cycle on RESET_PC before the first real fetch.
        state_d = FETCH;
      end else begin
        // FETCH, or STALLED with Stall released: deliver the word at the PC.
        state_d       = FETCH;
        ifid_instr_d  = Instruction;
        ifid_pc_d     = pc_next_seq;
        ifid_valid_d  = 1'b1;
        pc_d          = pc_next_seq;
        fetch_count_d = fetch_count_inc;
      end
    end
  end

  assign InstructionAddress = pc_q;
  assign IfIdInstruction    = ifid_instr_q;
  assign IfIdPC             = ifid_pc_q;
  assign IfIdValid          = ifid_valid_q;
  assign Halted             = (state_q == HALTED);
  assign FetchCount         = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a behavioural model predicts
// the outputs after every edge and queues them; a monitor pops and compares.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0000)
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic [15:0] instruction, instruction_address;
  logic [15:0] ifid_instruction, ifid_pc, fetch_count;
  logic        ifid_valid, halted;

  // Second DUT (RESET_PC = FFFE) for the PC wrap case
  logic        w_reset = 1'b1;
  logic [15:0] w_instruction, w_instruction_address;
  logic [15:0] w_ifid_instruction, w_ifid_pc, w_fetch_count;
  logic        w_ifid_valid, w_halted;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents: two fixed words plus a scrambled fill.
  function automatic logic [15:0] imem(input logic [15:0] a);
    logic [15:0] r;
    case (a)
      16'h0000: r = 16'h1FC0;
      16'h0006: r = 16'h8000;
      default:  r = (a * 16'h9E37) ^ 16'h5A5A;
    endcase
    return r;
  endfunction

  assign instruction   = imem(instruction_address);
  assign w_instruction = imem(w_instruction_address);

  instruction_fetch_unit dut (
    .Clk               (clk),
    .Reset             (reset),
    .InstructionAddress(instruction_address),
    .Instruction       (instruction),
    .Stall             (stall),
    .Redirect          (redirect),
    .RedirectTarget    (redirect_target),
    .Halt              (halt),
    .IfIdInstruction   (ifid_instruction),
    .IfIdPC            (ifid_pc),
    .IfIdValid         (ifid_valid),
    .Halted            (halted),
    .FetchCount        (fetch_count)
  );

  instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .Clk               (clk),
    .Reset             (w_reset),
    .InstructionAddress(w_instruction_address),
    .Instruction       (w_instruction),
    .Stall             (1'b0),
    .Redirect          (1'b0),
    .RedirectTarget    (16'h0000),
    .Halt              (1'b0),
    .IfIdInstruction   (w_ifid_instruction),
    .IfIdPC            (w_ifid_pc),
    .IfIdValid         (w_ifid_valid),
    .Halted            (w_halted),
    .FetchCount        (w_fetch_count)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected outputs after one clock edge
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] ifpc;
    logic [15:0] count;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural view (PC, IF/ID slot, counter, halted flag,
  // and whether the post-reset settling cycle is still pending).
  logic [15:0] m_pc, m_instr, m_ifpc, m_count;
  logic        m_valid, m_halted, m_booting;

  // Drive one cycle of stimulus, advance the model, queue the prediction.
  task automatic step(input logic r, input logic rd, input logic [15:0] tgt,
                      input logic h, input logic s);
    exp_t e;
    @(negedge clk);
    reset = r; redirect = rd; redirect_target = tgt; halt = h; stall = s;
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000; m_count = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_booting = 1'b1;
    end else if (m_halted) begin
      // frozen until reset
    end else if (rd) begin
      m_pc = tgt; m_valid = 1'b0; m_instr = 16'h0000; m_booting = 1'b0;
    end else if (h) begin
      m_halted = 1'b1; m_valid = 1'b0; m_instr = 16'h0000;
    end else if (s) begin
      m_booting = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else begin
      m_instr = imem(m_pc);
      m_pc    = m_pc + 16'd1;
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
    e.addr = m_pc; e.instr = m_instr; e.ifpc = m_ifpc; e.count = m_count;
    e.valid = m_valid; e.halted = m_halted;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT outputs against each queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_addr",   instruction_address, e.addr);
        check("sb_instr",  ifid_instruction,    e.instr);
        check("sb_ifpc",   ifid_pc,             e.ifpc);
        check("sb_valid",  {15'b0, ifid_valid}, {15'b0, e.valid});
        check("sb_halted", {15'b0, halted},     {15'b0, e.halted});
        check("sb_count",  fetch_count,         e.count);
      end
    end
  end

  initial begin
    // PC wrap on the RESET_PC = FFFE instance; main DUT held in reset.
    repeat (2) @(negedge clk);
    w_reset = 1'b0;
    after_edge();
    check("wrap_boot_addr",  w_instruction_address, 16'hFFFE);
    check("wrap_boot_valid", {15'b0, w_ifid_valid}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a;
      a = 16'hFFFE + 16'(i);
      after_edge();
      check("wrap_addr",  w_instruction_address, a + 16'd1);
      check("wrap_ifpc",  w_ifid_pc,             a + 16'd1);
      check("wrap_instr", w_ifid_instruction,    imem(a));
    end

    // Free run after reset
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    after_edge();
    check("boot_valid", {15'b0, ifid_valid}, 16'h0000);
    check("boot_addr",  instruction_address, 16'h0000);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      after_edge();
      check("run_instr", ifid_instruction, imem(16'(i)));
      check("run_ifpc",  ifid_pc,          16'(i + 1));
    end
    check("run_word0006", ifid_instruction, 16'h8000);
    check("run_count",    fetch_count,      16'd7);

    // Stall three cycles while PC = 0003
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      after_edge();
      check("stall_instr", ifid_instruction,    imem(16'h0002));
      check("stall_addr",  instruction_address, 16'h0003);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    after_edge();
    check("unstall_instr", ifid_instruction, imem(16'h0003));
    check("unstall_count", fetch_count,      16'd4);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    after_edge();
    check("unstall_next", ifid_instruction, imem(16'h0004));
    check("unstall_cnt2", fetch_count,      16'd5);

    // Redirect to 0005 with Stall, while PC = 0002
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1);
    after_edge();
    check("redir_valid", {15'b0, ifid_valid}, 16'h0000);
    check("redir_addr",  instruction_address, 16'h0005);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    after_edge();
    check("redir_instr", ifid_instruction,    imem(16'h0005));
    check("redir_ifpc",  ifid_pc,             16'h0006);
    check("redir_vld1",  {15'b0, ifid_valid}, 16'h0001);

    // Halt at PC = 0004, then Redirect/Stall are ignored
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    after_edge();
    check("halt_flag",  {15'b0, halted},     16'h0001);
    check("halt_valid", {15'b0, ifid_valid}, 16'h0000);
    check("halt_addr",  instruction_address, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
      after_edge();
      check("halt_hold_addr", instruction_address, 16'h0004);
      check("halt_hold_flag", {15'b0, halted},     16'h0001);
    end
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    after_edge();
    check("halt_reset_addr", instruction_address, 16'h0000);
    check("halt_reset_flag", {15'b0, halted},     16'h0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, rd, h, s;
      logic [15:0] tgt;
      r  = ($urandom_range(0, 63) == 0);
      rd = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) tgt = {14'h3FFF, 2'($urandom_range(0, 3))};
      else                           tgt = 16'($urandom);
      step(r, rd, tgt, h, s);
    end

    // Saturation of FetchCount
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    after_edge();
    check("sat_count", fetch_count, 16'hFFFF);

    after_edge();
    check("sb_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
